// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants and types for the seven-segment display path
package display_pkg;
  localparam int NUM_DIGITS = 8;
  localparam int SEL_WIDTH  = 3;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 8'hFF;

  typedef logic [SEL_WIDTH-1:0] digit_sel_t;
endpackage

// File: rtl/next_digit_finder.sv
// rtl/next_digit_finder.sv - wrap-around search for the next enabled digit after the current one
module next_digit_finder
  import display_pkg::*;
(
  input  digit_sel_t            current,
  input  logic [NUM_DIGITS-1:0] digit_mask,
  output digit_sel_t            next_index,
  output digit_sel_t            lowest_index,
  output logic                  any_enabled
);
  digit_sel_t idx;

  always_comb begin
    next_index   = current;
    lowest_index = '0;
    any_enabled  = |digit_mask;
    idx          = '0;
    // Search farthest-first so the nearest enabled digit wins; k=8 wraps onto current itself.
    for (int k = NUM_DIGITS; k >= 1; k--) begin
      idx = current + SEL_WIDTH'(k);
      if (digit_mask[idx]) next_index = idx;
    end
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (digit_mask[i]) lowest_index = SEL_WIDTH'(i);
    end
  end
endmodule

// File: rtl/digit_scan_ctrl.sv
// rtl/digit_scan_ctrl.sv - time-multiplexed digit scan with dwell prescaler, digit skip and blink
module digit_scan_ctrl
  import display_pkg::*;
#(
  parameter int DIV_WIDTH   = 16,
  parameter int BLINK_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [DIV_WIDTH-1:0]   divisor,
  input  logic [NUM_DIGITS-1:0]  digit_mask,
  input  logic [NUM_DIGITS-1:0]  blink_mask,
  input  logic [BLINK_WIDTH-1:0] blink_period,
  output digit_sel_t             select,
  output logic [NUM_DIGITS-1:0]  anode,
  output logic                   tick,
  output logic                   frame_start,
  output logic                   blink_on
);
  logic [DIV_WIDTH-1:0]   prescaler;
  logic [BLINK_WIDTH-1:0] frame_cnt;
  digit_sel_t             next_index;
  digit_sel_t             lowest_index;
  logic                   any_enabled;
  logic                   terminal;
  logic                   frame_hit;
  logic                   blink_wrap;
  logic [NUM_DIGITS-1:0]  anode_next;

  next_digit_finder u_finder (
    .current      (select),
    .digit_mask   (digit_mask),
    .next_index   (next_index),
    .lowest_index (lowest_index),
    .any_enabled  (any_enabled)
  );

  // >= so that shrinking the divisor below the running count ends the dwell at once.
  assign terminal   = enable && (prescaler >= divisor);
  assign frame_hit  = terminal && any_enabled && (next_index == lowest_index);
  assign blink_wrap = ({1'b0, frame_cnt} + (BLINK_WIDTH + 1)'(1)) >= {1'b0, blink_period};

  // Anode reflects the select already presented to the mux, matching its one-cycle register.
  always_comb begin
    anode_next = ANODE_OFF;
    if (digit_mask[select] && !(!blink_on && blink_mask[select])) anode_next[select] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      select      <= '0;
      prescaler   <= '0;
      frame_cnt   <= '0;
      blink_on    <= 1'b1;
      tick        <= 1'b0;
      frame_start <= 1'b0;
      anode       <= ANODE_OFF;
    end else begin
      anode       <= anode_next;
      tick        <= terminal;
      frame_start <= frame_hit;
      if (enable) begin
        prescaler <= terminal ? '0 : prescaler + DIV_WIDTH'(1);
        if (terminal && any_enabled) select <= next_index;
        if (blink_period == '0) begin
          frame_cnt <= '0;
          blink_on  <= 1'b1;
        end else if (frame_hit) begin
          if (blink_wrap) begin
            frame_cnt <= '0;
            blink_on  <= !blink_on;
          end else begin
            frame_cnt <= frame_cnt + BLINK_WIDTH'(1);
          end
        end
      end
    end
  end
endmodule
